// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and frame size for the SPI slave sequencer
package spi_pkg;

  localparam int FRAME_BITS_DEF = 8;
  localparam int CNT_W_DEF      = 4;

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_GET_ADDR     = 4'd1,
    S_ADDR_LATCH   = 4'd2,
    S_READ_WAIT    = 4'd3,
    S_READ_LOAD    = 4'd4,
    S_READ_SHIFT   = 4'd5,
    S_WRITE_SHIFT  = 4'd6,
    S_WRITE_COMMIT = 4'd7,
    S_DONE         = 4'd8
  } spi_state_t;

endpackage

// File: rtl/frame_bit_counter.sv
// rtl/frame_bit_counter.sv - per-frame SCLK bit counter with terminal flag
module frame_bit_counter #(
  parameter int FRAME_BITS = spi_pkg::FRAME_BITS_DEF,
  parameter int CNT_W      = spi_pkg::CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count,
  output logic             o_terminal
);

  logic [CNT_W-1:0] r_count;

  // Clear wins over increment so a frame boundary never leaks a stale count.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count    = r_count;
  assign o_terminal = i_inc && (r_count == CNT_W'(FRAME_BITS - 1));

endmodule

// File: rtl/spi_control_fsm.sv
// rtl/spi_control_fsm.sv - SPI memory slave transaction sequencer (Moore, registered strobes)
module spi_control_fsm
  import spi_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_cs_n,
  input  logic i_sclk_pos,
  input  logic i_sclk_neg,
  input  logic i_rw_bit,
  output logic o_addr_we,
  output logic o_dm_we,
  output logic o_sr_load,
  output logic o_miso_en,
  output logic o_busy
);

  spi_state_t       r_state;
  logic             r_addr_we;
  logic             r_dm_we;
  logic             r_sr_load;
  logic             r_miso_en;
  logic             r_busy;
  logic             w_counting;
  logic             w_cnt_inc;
  logic             w_cnt_clr;
  logic             w_term;
  logic [CNT_W-1:0] w_count;
  logic             w_unused_sclk_neg;

  // sclk_neg only matters to the MISO buffer, not to frame sequencing.
  assign w_unused_sclk_neg = i_sclk_neg;

  assign w_counting = (r_state == S_GET_ADDR) || (r_state == S_READ_SHIFT) ||
                      (r_state == S_WRITE_SHIFT);
  assign w_cnt_inc  = w_counting && i_sclk_pos && !i_cs_n;
  // Holding the counter clear outside shift states zeroes it on every state entry.
  assign w_cnt_clr  = i_cs_n || !w_counting || w_term;

  frame_bit_counter #(
    .FRAME_BITS (FRAME_BITS),
    .CNT_W      (CNT_W)
  ) u_bit_cnt (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_clear    (w_cnt_clr),
    .i_inc      (w_cnt_inc),
    .o_count    (w_count),
    .o_terminal (w_term)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_addr_we <= 1'b0;
      r_dm_we   <= 1'b0;
      r_sr_load <= 1'b0;
      r_miso_en <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_addr_we <= 1'b0;
      r_dm_we   <= 1'b0;
      r_sr_load <= 1'b0;
      r_miso_en <= 1'b0;
      r_busy    <= 1'b1;
      if (i_cs_n) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        // Outputs are decoded from the state being entered, so each strobe
        // is high for exactly the one clk spent in its state.
        case (r_state)
          S_IDLE:         r_state <= S_GET_ADDR;
          S_GET_ADDR: begin
            if (w_term) begin
              r_state   <= S_ADDR_LATCH;
              r_addr_we <= 1'b1;
            end
          end
          S_ADDR_LATCH:   r_state <= i_rw_bit ? S_READ_WAIT : S_WRITE_SHIFT;
          S_READ_WAIT: begin
            r_state   <= S_READ_LOAD;
            r_sr_load <= 1'b1;
          end
          S_READ_LOAD: begin
            r_state   <= S_READ_SHIFT;
            r_miso_en <= 1'b1;
          end
          S_READ_SHIFT: begin
            if (w_term) r_state   <= S_DONE;
            else        r_miso_en <= 1'b1;
          end
          S_WRITE_SHIFT: begin
            if (w_term) begin
              r_state <= S_WRITE_COMMIT;
              r_dm_we <= 1'b1;
            end
          end
          S_WRITE_COMMIT: r_state <= S_DONE;
          S_DONE:         r_state <= S_DONE;
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_addr_we = r_addr_we;
  assign o_dm_we   = r_dm_we;
  assign o_sr_load = r_sr_load;
  assign o_miso_en = r_miso_en;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_spi_control_fsm.sv
// tb/tb_spi_control_fsm.sv - directed bench for spi_control_fsm
module tb_spi_control_fsm;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic reset_n, cs_n, sclk_pos, sclk_neg, rw_bit;
  logic addr_we, dm_we, sr_load, miso_en, busy;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spi_control_fsm dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_cs_n     (cs_n),
    .i_sclk_pos (sclk_pos),
    .i_sclk_neg (sclk_neg),
    .i_rw_bit   (rw_bit),
    .o_addr_we  (addr_we),
    .o_dm_we    (dm_we),
    .o_sr_load  (sr_load),
    .o_miso_en  (miso_en),
    .o_busy     (busy)
  );

  // Expected vector order: {addr_we, dm_we, sr_load, miso_en, busy}
  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {addr_we, dm_we, sr_load, miso_en, busy};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    sclk_pos = 1'b1;
    sclk_neg = 1'b0;
    tick();
    sclk_pos = 1'b0;
    sclk_neg = 1'b1;
    tick();
    sclk_neg = 1'b0;
  endtask

  task automatic addr_frame(input string tag, input logic rw);
    rw_bit = rw;
    cs_n   = 1'b0;
    tick();
    chk({tag, "_sel"}, 5'b00001);
    for (int i = 0; i < FRAME_BITS_DEF - 1; i++) begin
      sclk_pos = 1'b1;
      tick();
      sclk_pos = 1'b0;
      chk({tag, "_addr_bit"}, 5'b00001);
    end
    sclk_pos = 1'b1;
    tick();
    sclk_pos = 1'b0;
    chk({tag, "_addr_we"}, 5'b10001);
  endtask

  task automatic write_frame(input string tag);
    addr_frame(tag, 1'b0);
    tick();
    chk({tag, "_wshift"}, 5'b00001);
    for (int i = 0; i < FRAME_BITS_DEF - 1; i++) pulse();
    chk({tag, "_wbits"}, 5'b00001);
    sclk_pos = 1'b1;
    tick();
    sclk_pos = 1'b0;
    chk({tag, "_dm_we"}, 5'b01001);
    tick();
    chk({tag, "_done"}, 5'b00001);
    pulse();
    chk({tag, "_done_extra_sclk"}, 5'b00001);
  endtask

  task automatic read_frame(input string tag);
    addr_frame(tag, 1'b1);
    tick();
    chk({tag, "_rwait"}, 5'b00001);
    tick();
    chk({tag, "_sr_load"}, 5'b00101);
    tick();
    chk({tag, "_miso_on"}, 5'b00011);
    for (int i = 0; i < FRAME_BITS_DEF - 1; i++) begin
      pulse();
      chk({tag, "_rbit"}, 5'b00011);
    end
    sclk_pos = 1'b1;
    tick();
    sclk_pos = 1'b0;
    chk({tag, "_rdone"}, 5'b00001);
  endtask

  initial begin
    reset_n = 1'b0; cs_n = 1'b1; sclk_pos = 1'b0; sclk_neg = 1'b0; rw_bit = 1'b0;
    tick(); tick();
    chk("reset", 5'b00000);
    reset_n = 1'b1;
    tick();
    chk("idle_cs_high", 5'b00000);

    write_frame("wr1");
    cs_n = 1'b1;
    tick();
    chk("wr1_idle", 5'b00000);

    read_frame("rd1");
    cs_n = 1'b1;
    tick();
    chk("rd1_idle", 5'b00000);

    cs_n = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) pulse();
    chk("abort_mid", 5'b00001);
    cs_n = 1'b1;
    tick();
    chk("abort_idle", 5'b00000);
    tick();
    chk("abort_idle2", 5'b00000);
    write_frame("wr_after_abort");
    cs_n = 1'b1;
    tick();
    chk("wr_after_abort_idle", 5'b00000);

    addr_frame("rst_rd", 1'b1);
    tick(); tick(); tick();
    chk("rst_rd_shift", 5'b00011);
    pulse(); pulse(); pulse();
    reset_n = 1'b0;
    tick();
    chk("rst_rd_reset", 5'b00000);
    reset_n = 1'b1;
    cs_n = 1'b1;
    tick();
    chk("rst_rd_idle", 5'b00000);

    addr_frame("cs_coinc", 1'b0);
    tick();
    for (int i = 0; i < FRAME_BITS_DEF - 1; i++) pulse();
    cs_n = 1'b1;
    sclk_pos = 1'b1;
    tick();
    sclk_pos = 1'b0;
    chk("cs_coinc_no_dm_we", 5'b00000);
    tick();
    chk("cs_coinc_idle", 5'b00000);

    write_frame("b2b_wr");
    cs_n = 1'b1;
    tick();
    chk("b2b_gap1", 5'b00000);
    tick();
    chk("b2b_gap2", 5'b00000);
    read_frame("b2b_rd");
    cs_n = 1'b1;
    tick();
    chk("b2b_end", 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
